// File: rtl/matrix_mem_arbiter_pkg.sv
// Shared constants for the matrix RAM arbiter: geometry, port indices and the pointer-advance helper.
package matrix_mem_arbiter_pkg;
  localparam int ADDR_WIDTH = 7;
  localparam int DATA_WIDTH = 4;
  localparam int DEPTH      = 96;
  localparam int NUM_PORTS  = 3;

  localparam logic [1:0] PORT_LOAD = 2'd0;
  localparam logic [1:0] PORT_FUNC = 2'd1;
  localparam logic [1:0] PORT_DISP = 2'd2;

  function automatic logic [1:0] next_ptr(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction
endpackage

// File: rtl/matrix_mem_arbiter_rr_pick3.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ptr+2 (mod 3).
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);
  always_comb begin : pick
    logic found;
    int   idx;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < 3; k++) begin
      idx = (int'(ptr) + k) % 3;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/matrix_mem_arbiter.sv
// Arbitrates the single matrix RAM between loader, compute and display ports with
// round-robin priority, an exclusive lock, out-of-range dropping and tagged read return.
module matrix_mem_arbiter
  import matrix_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int DEPTH_P = DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [2:0]            lock,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic [2:0]            err,
  output logic                  owner_valid,
  output logic [1:0]            owner,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);
  logic [1:0]        ptr;
  logic [1:0]        gidx;
  logic [2:0]        pick_req;
  logic [2:0]        in_range;
  logic              acc_ok;
  logic [DATA_W-1:0] rdata_q;

  for (genvar i = 0; i < 3; i++) begin : g_range
    assign in_range[i] = 32'(addr[i*ADDR_W +: ADDR_W]) < DEPTH_P;
  end

  // While locked only the owner may compete; reset forces a quiet bus immediately.
  always_comb begin
    pick_req = req;
    if (owner_valid) pick_req = req & (3'b001 << owner);
    if (reset)       pick_req = '0;
  end

  rr_pick3 u_pick (.req(pick_req), .ptr(ptr), .gnt(gnt));

  always_comb begin
    case (gnt)
      3'b010:  gidx = PORT_FUNC;
      3'b100:  gidx = PORT_DISP;
      default: gidx = PORT_LOAD;
    endcase
  end

  // Out-of-range grants still acknowledge the requester but never touch the RAM.
  assign acc_ok    = (|gnt) && in_range[gidx];
  assign mem_en    = acc_ok;
  assign mem_we    = acc_ok && we[gidx];
  assign mem_addr  = acc_ok ? addr[int'(gidx)*ADDR_W +: ADDR_W]  : '0;
  assign mem_wdata = acc_ok ? wdata[int'(gidx)*DATA_W +: DATA_W] : '0;

  assign rdata = (|rvalid) ? mem_rdata : rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= 2'd0;
      owner_valid <= 1'b0;
      owner       <= 2'd0;
      rvalid      <= '0;
      err         <= '0;
      rdata_q     <= '0;
    end else begin
      rvalid <= gnt & ~we & in_range;
      err    <= gnt & ~in_range;
      if (|rvalid) rdata_q <= mem_rdata;
      if (!owner_valid) begin
        if (|gnt) begin
          ptr <= next_ptr(gidx);
          if (lock[gidx]) begin
            owner_valid <= 1'b1;
            owner       <= gidx;
          end
        end
      end else if (!lock[owner]) begin
        owner_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_matrix_mem_arbiter.sv
// Directed table-driven bench for matrix_mem_arbiter with a behavioural synchronous RAM.
module tb_matrix_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, we, lock;
  logic [20:0] addr;
  logic [11:0] wdata;
  logic [2:0]  gnt, rvalid, err;
  logic [3:0]  rdata;
  logic        owner_valid;
  logic [1:0]  owner;
  logic        mem_en, mem_we;
  logic [6:0]  mem_addr;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata;

  logic [3:0]  ram [0:127];
  int          n_pass = 0;
  int          n_total = 0;

  typedef struct {
    logic [2:0]  req, we, lock;
    logic [20:0] addr;
    logic [11:0] wdata;
    logic [2:0]  gnt, rv;
    logic [3:0]  rd;
    logic [2:0]  err;
    logic        ov, men, mwe;
  } vec_t;

  vec_t vecs[$];

  matrix_mem_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
    .owner_valid(owner_valid), .owner(owner), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l,
                     input int a0, input int a1, input int a2, input logic [11:0] wd,
                     input logic [2:0] g, input logic [2:0] rv, input logic [3:0] rd,
                     input logic [2:0] e, input logic ov, input logic men, input logic mwe);
    vec_t v;
    v.req = r; v.we = w; v.lock = l;
    v.addr = {7'(a2), 7'(a1), 7'(a0)};
    v.wdata = wd;
    v.gnt = g; v.rv = rv; v.rd = rd; v.err = e; v.ov = ov; v.men = men; v.mwe = mwe;
    vecs.push_back(v);
  endtask

  initial begin
    for (int a = 0; a < 128; a++) ram[a] = 4'(a);
    mem_rdata = '0;
    reset = 1'b1;
    req = 3'b111; we = '0; lock = '0; addr = {7'd5, 7'd5, 7'd5}; wdata = '0;

    // req, we, lock, a0, a1, a2, wdata | gnt, rvalid, rdata, err, owner_valid, mem_en, mem_we
    add(3'b111, 3'b000, 3'b000,  5, 40, 70, 12'h000, 3'b001, 3'b000, 4'h0, 3'b000, 0, 1, 0);
    add(3'b111, 3'b000, 3'b000,  5, 40, 70, 12'h000, 3'b010, 3'b001, 4'h5, 3'b000, 0, 1, 0);
    add(3'b111, 3'b000, 3'b000,  5, 40, 70, 12'h000, 3'b100, 3'b010, 4'h8, 3'b000, 0, 1, 0);
    add(3'b000, 3'b000, 3'b000,  5, 40, 70, 12'h000, 3'b000, 3'b100, 4'h6, 3'b000, 0, 0, 0);
    add(3'b000, 3'b000, 3'b000,  5, 40, 70, 12'h000, 3'b000, 3'b000, 4'h6, 3'b000, 0, 0, 0);
    // lock by port 1, writes 0xA to 64
    add(3'b010, 3'b010, 3'b010,  0, 64,  0, 12'h0A0, 3'b010, 3'b000, 4'h6, 3'b000, 0, 1, 1);
    add(3'b101, 3'b000, 3'b010,  5, 64, 70, 12'h000, 3'b000, 3'b000, 4'h6, 3'b000, 1, 0, 0);
    add(3'b111, 3'b000, 3'b010,  5, 64, 70, 12'h000, 3'b010, 3'b000, 4'h6, 3'b000, 1, 1, 0);
    add(3'b101, 3'b000, 3'b000,  5, 64, 70, 12'h000, 3'b000, 3'b010, 4'hA, 3'b000, 1, 0, 0);
    add(3'b101, 3'b000, 3'b000,  5, 64, 70, 12'h000, 3'b100, 3'b000, 4'hA, 3'b000, 0, 1, 0);
    add(3'b101, 3'b000, 3'b000,  5, 64, 70, 12'h000, 3'b001, 3'b100, 4'h6, 3'b000, 0, 1, 0);
    add(3'b000, 3'b000, 3'b000,  5, 64, 70, 12'h000, 3'b000, 3'b001, 4'h5, 3'b000, 0, 0, 0);
    // out-of-range read
    add(3'b001, 3'b000, 3'b000, 100, 0,  0, 12'h000, 3'b001, 3'b000, 4'h5, 3'b000, 0, 0, 0);
    add(3'b000, 3'b000, 3'b000, 100, 0,  0, 12'h000, 3'b000, 3'b000, 4'h5, 3'b001, 0, 0, 0);
    add(3'b000, 3'b000, 3'b000, 100, 0,  0, 12'h000, 3'b000, 3'b000, 4'h5, 3'b000, 0, 0, 0);
    // port 2 reading, port 0 writing continuously
    add(3'b101, 3'b001, 3'b000, 10,  0, 70, 12'h00C, 3'b100, 3'b000, 4'h5, 3'b000, 0, 1, 0);
    add(3'b101, 3'b001, 3'b000, 10,  0, 70, 12'h00C, 3'b001, 3'b100, 4'h6, 3'b000, 0, 1, 1);
    add(3'b101, 3'b001, 3'b000, 10,  0, 70, 12'h00C, 3'b100, 3'b000, 4'h6, 3'b000, 0, 1, 0);
    add(3'b101, 3'b001, 3'b000, 10,  0, 70, 12'h00C, 3'b001, 3'b100, 4'h6, 3'b000, 0, 1, 1);
    add(3'b000, 3'b000, 3'b000, 10,  0, 70, 12'h000, 3'b000, 3'b000, 4'h6, 3'b000, 0, 0, 0);
    // owner drops lock and req together while port 0 waits
    add(3'b010, 3'b000, 3'b010,  0, 10,  0, 12'h000, 3'b010, 3'b000, 4'h6, 3'b000, 0, 1, 0);
    add(3'b001, 3'b000, 3'b000,  5, 10,  0, 12'h000, 3'b000, 3'b010, 4'hC, 3'b000, 1, 0, 0);
    add(3'b001, 3'b000, 3'b000,  5, 10,  0, 12'h000, 3'b001, 3'b000, 4'hC, 3'b000, 0, 1, 0);
    add(3'b000, 3'b000, 3'b000,  5, 10,  0, 12'h000, 3'b000, 3'b001, 4'h5, 3'b000, 0, 0, 0);

    // reset state, with requests still asserted
    @(negedge clk); @(negedge clk); #1;
    chk("rst.gnt", 32'(gnt), 32'b0);
    chk("rst.rvalid", 32'(rvalid), 32'b0);
    chk("rst.rdata", 32'(rdata), 32'h0);
    chk("rst.err", 32'(err), 32'b0);
    chk("rst.owner_valid", 32'(owner_valid), 32'b0);
    chk("rst.owner", 32'(owner), 32'd0);
    chk("rst.mem_en", 32'(mem_en), 32'b0);
    chk("rst.mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0; req = '0;

    foreach (vecs[i]) begin
      @(negedge clk);
      req = vecs[i].req; we = vecs[i].we; lock = vecs[i].lock;
      addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      chk($sformatf("v%0d.gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("v%0d.rvalid", i), 32'(rvalid), 32'(vecs[i].rv));
      chk($sformatf("v%0d.rdata", i), 32'(rdata), 32'(vecs[i].rd));
      chk($sformatf("v%0d.err", i), 32'(err), 32'(vecs[i].err));
      chk($sformatf("v%0d.owner_valid", i), 32'(owner_valid), 32'(vecs[i].ov));
      chk($sformatf("v%0d.mem_en", i), 32'(mem_en), 32'(vecs[i].men));
      chk($sformatf("v%0d.mem_we", i), 32'(mem_we), 32'(vecs[i].mwe));
    end

    // reset between a locked read grant and its rvalid
    @(negedge clk);
    req = 3'b010; we = '0; lock = 3'b010; addr = {7'd5, 7'd5, 7'd5};
    #1 chk("mid.gnt", 32'(gnt), 32'b010);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid.rvalid", 32'(rvalid), 32'b0);
    chk("mid.owner_valid", 32'(owner_valid), 32'b0);
    chk("mid.mem_en", 32'(mem_en), 32'b0);
    chk("mid.gnt_in_reset", 32'(gnt), 32'b0);
    @(negedge clk);
    reset = 1'b0; req = 3'b111; lock = '0;
    #1 chk("mid.ptr_cleared", 32'(gnt), 32'b001);
    @(negedge clk);
    req = '0;
    #1 chk("mid.rvalid_after", 32'(rvalid), 32'b001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/matrix_mem_arbiter.md
# matrix_mem_arbiter

Shares the single matrix storage RAM between three requesters: the matrix input loader (port 0), the functions/compute unit (port 1) and the display/readback unit (port 2). It grants at most one access per cycle under round-robin priority. A lock lets a requester, normally the compute unit during a whole operation, own the RAM exclusively. Read data returns one cycle after grant and is tagged to the requester that issued the read.

## Interface
Parameters:
- `ADDR_WIDTH`, 7: RAM address width.
- `DATA_WIDTH`, 4: matrix element width.
- `DEPTH`, 96: valid words. An address ≥ DEPTH is out of range.

Ports (port i occupies bit i, or slice [i*W +: W]):
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `req`  in  3  access request per port; level, held until granted
- `we`  in  3  1 = write, 0 = read; qualified by req
- `lock`  in  3  request or hold exclusive ownership
- `addr`  in  3*ADDR_WIDTH  per-port address
- `wdata`  in  3*DATA_WIDTH  per-port write data
- `gnt`  out  3  one-hot or zero; access accepted this cycle (combinational)
- `rvalid`  out  3  registered; read data valid for that port
- `rdata`  out  DATA_WIDTH  read data, shared by all ports, qualified by rvalid
- `err`  out  3  registered one-cycle pulse; out-of-range access was dropped
- `owner_valid`  out  1  a lock is held
- `owner`  out  2  locking port index
- `mem_en`, `mem_we`  out  1  RAM strobe and write enable
- `mem_addr`  out  ADDR_WIDTH
- `mem_wdata`  out  DATA_WIDTH
- `mem_rdata`  in  DATA_WIDTH  synchronous RAM output, valid the cycle after mem_en with !mem_we

## Operation
- State `ptr` (0..2) marks the highest-priority port. State `owner_valid`/`owner` records the lock.
- Unlocked: the first port with req set, scanning ptr, ptr+1, ptr+2 (mod 3), is granted. After a grant to port i, `ptr` becomes (i+1) mod 3.
- Locked: only `owner` may be granted. Other requests wait with no grant and no error. `ptr` is frozen.
- Lock acquire: a port is granted with lock[i]=1 while no lock is held. From the next cycle owner_valid=1 and owner=i.
- Lock release: sampled lock[owner]=0 sets owner_valid to 0 the next cycle. Release needs no req. The release cycle itself still serves only the owner.
- Granted access drives mem_en=1, mem_we=we[i], mem_addr=addr[i], mem_wdata=wdata[i] in the same cycle. When no port is granted, all mem_* outputs are 0.
- Out-of-range (addr ≥ DEPTH): gnt is still asserted so the requester does not stall. mem_en stays 0. err[i] pulses the next cycle. No rvalid is produced. ptr and lock update as for a normal grant.
- Read: rvalid[i]=1 and rdata=mem_rdata in the cycle after the grant. rdata holds its last value otherwise.
- Back-to-back grants are allowed every cycle, including one port reading on consecutive cycles.

## Timing
- Grant latency: 0 cycles, combinational from req, ptr and owner.
- Read latency: 1 cycle, grant to rvalid. Write completes at the grant edge.
- Reset values: gnt=0, rvalid=0, rdata=0, err=0, owner_valid=0, owner=0, ptr=0, all mem_*=0.
- Reset mid-operation: a pending rvalid is dropped and the lock is cleared. Requesters must re-request.
- Simultaneous lock acquire and another port's request: round-robin decides. The loser waits until release.
- Owner deasserts lock and req in the same cycle: no grant that cycle, and the lock is released next cycle.
- Starvation bound, unlocked: a held request is granted within 3 cycles.

## Structure
- Shared package/defines file holds `ADDR_WIDTH`, `DATA_WIDTH`, `DEPTH`, and the port index constants `PORT_LOAD`=0, `PORT_FUNC`=1, `PORT_DISP`=2.
- One sub-module, `rr_pick3`: a combinational round-robin picker that takes req[2:0] and ptr[1:0] and returns a one-hot grant. The arbiter masks its input with the owner when a lock is held.

## Test plan
- All three ports read with ptr=0 and addrs 5, 40, 70 held for 3 cycles → gnt 001, 010, 100 on consecutive cycles; rvalid follows each by 1 cycle; rdata matches RAM contents.
- Port 1 writes with lock=1 at addr 64, data 0xA, while ports 0 and 2 request → ports 0 and 2 get no grant until lock drops; then they are served in order 2, 0 (ptr=2); a read of 64 returns 0xA.
- Port 0 reads addr 100 with DEPTH=96 → gnt[0]=1, mem_en=0, err[0]=1 next cycle, rvalid[0]=0.
- Port 2 reads continuously while port 0 writes continuously → grants alternate 100, 001; no cycle is idle while a request is pending.
- Reset asserted during a locked read (cycle between grant and rvalid) → rvalid stays 0, owner_valid=0, ptr=0, mem_en=0 immediately.
- Owner drops lock and req in the same cycle while port 0 requests → port 0 gets no grant that cycle and is granted the next cycle.
